// File: rtl/time_counter.sv
// time_counter
//
// Time-keeping core of the electronic clock. Counts 24-hour time, with BCD
// seconds and minutes and binary hours, advanced by a 1 Hz enable. The user
// sets hours and then minutes with two debounced one-pulse buttons. Hours
// always run 0-23; the downstream scan stage handles any 12-hour display.
//
// Parameters
//   INIT_HOUR  hour loaded at reset (binary, 0-23)
//   INIT_MIN   minutes loaded at reset (BCD {tens, units}, 00-59)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick_1hz   one-cycle enable, once per second
//   set_btn    one-pulse: RUN -> SET_HOUR -> SET_MIN -> RUN
//   inc_btn    one-pulse: increments the field selected by the setting state
//   sec1/sec2  seconds units/tens (BCD)
//   min1/min2  minutes units/tens (BCD)
//   hour       hours (binary 0-23)
//   setting    state code: 00 RUN, 01 SET_HOUR, 10 SET_MIN
//   day_pulse  one-cycle pulse after the 23:59:59 -> 00:00:00 rollover
//
// All outputs come straight from registers.

module time_counter #(
  parameter logic [4:0] INIT_HOUR = 5'd0,
  parameter logic [7:0] INIT_MIN  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       set_btn,
  input  logic       inc_btn,
  output logic [3:0] sec1,
  output logic [3:0] sec2,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [4:0] hour,
  output logic [1:0] setting,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  state_t state;

  // Terminal-count flags for each digit of the carry chain.
  logic sec1_wrap;
  logic sec2_wrap;
  logic min1_wrap;
  logic min2_wrap;
  logic hour_wrap;

  always_comb begin
    sec1_wrap = (sec1 == 4'd9);
    sec2_wrap = (sec2 == 4'd5);
    min1_wrap = (min1 == 4'd9);
    min2_wrap = (min2 == 4'd5);
    hour_wrap = (hour == 5'd23);
  end

  assign setting = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      sec1      <= '0;
      sec2      <= '0;
      min1      <= INIT_MIN[3:0];
      min2      <= INIT_MIN[7:4];
      hour      <= INIT_HOUR;
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= 1'b0;

      case (state)
        RUN: begin
          // The tick is applied even when set_btn arrives on the same edge;
          // inc_btn has no meaning while running.
          if (tick_1hz) begin
            if (sec1_wrap) begin
              sec1 <= '0;
              if (sec2_wrap) begin
                sec2 <= '0;
                if (min1_wrap) begin
                  min1 <= '0;
                  if (min2_wrap) begin
                    min2 <= '0;
                    if (hour_wrap) begin
                      hour      <= '0;
                      day_pulse <= 1'b1;
                    end else begin
                      hour <= hour + 5'd1;
                    end
                  end else begin
                    min2 <= min2 + 4'd1;
                  end
                end else begin
                  min1 <= min1 + 4'd1;
                end
              end else begin
                sec2 <= sec2 + 4'd1;
              end
            end else begin
              sec1 <= sec1 + 4'd1;
            end
          end
          if (set_btn) begin
            state <= SET_HOUR;
          end
        end

        SET_HOUR: begin
          // Time is frozen; set_btn takes priority over inc_btn.
          if (set_btn) begin
            state <= SET_MIN;
          end else if (inc_btn) begin
            hour <= hour_wrap ? 5'd0 : hour + 5'd1;
          end
        end

        SET_MIN: begin
          if (set_btn) begin
            // Restart the minute cleanly when the user commits the time.
            state <= RUN;
            sec1  <= '0;
            sec2  <= '0;
          end else if (inc_btn) begin
            // Minutes wrap 59 -> 00 without carrying into the hour.
            if (min1_wrap) begin
              min1 <= '0;
              min2 <= min2_wrap ? 4'd0 : min2 + 4'd1;
            end else begin
              min1 <= min1 + 4'd1;
            end
          end
        end

        default: begin
          // Unreachable code 11: recover to RUN, leave the time untouched.
          state <= RUN;
        end
      endcase
    end
  end

endmodule
